decoder_scan_n: RTL
===================

Name: decoder_scan_n

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable. It is the sequential successor to the team's combinational 3x8 decoder. Besides direct decoding, it can auto-scan the output lines: continuously, or as a one-shot sweep with a dwell time per line. It drives row/digit selects for multiplexed displays and peripheral chip-selects in the lab designs.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (localparam, not overridable)
DWELL, 4, clock cycles each line stays selected in scan/sweep modes; legal range >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
E  in  1  enable; low forces outputs inactive and aborts any run
MODE  in  2  00 direct, 01 continuous scan, 10 one-shot sweep, 11 hold
A  in  SEL_W  direct-decode address / scan-sweep start index
START  in  1  single-cycle request: begins scan/sweep; stops a continuous scan
D  out  OUT_W  registered one-hot select
IDX  out  SEL_W  index currently selected (valid when D != 0)
BUSY  out  1  high while in SCAN or SWEEP
DONE  out  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset (async, rst=1): state IDLE, D=0, IDX=0, BUSY=0, DONE=0, dwell counter=0. Outputs are cleared immediately, without waiting for clk.
- States: IDLE, SCAN, SWEEP. MODE is sampled only in IDLE; MODE changes mid-run are ignored.
- IDLE, E=1, MODE=00: D <= 1<<A and IDX <= A every cycle. Latency is 1 clk from A to D.
- IDLE, MODE=11: D and IDX hold their last values.
- IDLE, E=0: D <= 0. IDX holds its value.
- IDLE, E=1, START=1, MODE=01 -> SCAN. IDLE, E=1, START=1, MODE=10 -> SWEEP. On entry: IDX <= A, D <= 1<<A, dwell counter <= 0, BUSY <= 1.
- IDLE, START=1 with MODE=00 or 11: START is ignored; the direct/hold behaviour applies.
- Dwell: the counter increments each cycle in SCAN/SWEEP. When it reaches DWELL-1, it clears and IDX advances by 1, with D following. Each line is therefore asserted for exactly DWELL cycles. DWELL=1 advances every cycle.
- SCAN wrap: IDX OUT_W-1 -> 0, repeating indefinitely.
- SCAN exit: START=1 -> IDLE next cycle with D=0, BUSY=0, no DONE. If START coincides with a dwell boundary, the stop wins and no advance occurs.
- SWEEP: lines run A..OUT_W-1 with no wrap. After the last dwell cycle of line OUT_W-1 -> IDLE. That transition cycle sets D=0, BUSY=0, DONE=1 for one cycle. DONE then returns to 0.
- SWEEP: START is ignored. A sweep with A=OUT_W-1 selects one line for DWELL cycles, then completes.
- E=0 in SCAN or SWEEP: abort to IDLE next cycle with D=0, BUSY=0, DONE=0, dwell counter cleared. E dominates START.
- Invariants: D is one-hot or zero, never multi-hot. IDX always equals log2(D) when D != 0.
- Dwell counter width is $clog2(DWELL+1) bits. The comparison is done in that width; there is no overflow.

Optional Feature:
Macro DEC_ACTIVE_LOW_EN.
- Defined: the D port is driven as the bitwise inverse of the internal one-hot, i.e. one-cold, 74x138 style. The reset value and every "D=0" above become all-ones.
- Undefined: active-high one-hot exactly as specified.
- IDX, BUSY and DONE are unaffected in both cases.

Decomposition:
- Shared package decoder_pkg: MODE encodings (MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_SWEEP=2'b10, MODE_HOLD=2'b11) and state encodings (ST_IDLE, ST_SCAN, ST_SWEEP).
- One sub-module, dwell_counter: parametrised DWELL, inputs clr/en, output tick on the last cycle. Its instance is reusable for display refresh timing.
- The one-hot decode stays inline as a registered shift.

Test Plan (SEL_W=3, DWELL=2 unless noted):
1. Reset/direct: assert rst mid-cycle -> D=0, BUSY=0 at once. Then E=1, MODE=00, A=0..7 -> D=8'h01,02,04,...,80 one clk after each A. E=0 -> D=8'h00.
2. Continuous scan: MODE=01, A=6, START pulse -> D=8'h40 x2 clk, 8'h80 x2, 8'h01 x2 (wrap), 8'h02... BUSY=1. START pulse -> D=0, BUSY=0 next clk, DONE never asserted.
3. Sweep: MODE=10, A=5, START -> D=8'h20,8'h20,8'h40,8'h40,8'h80,8'h80. Next clk D=0, BUSY=0, DONE=1 for exactly one clk. START pulses during the sweep are ignored.
4. Abort: during a sweep at IDX=3, drop E -> next clk D=0, BUSY=0, DONE=0. Raise E with MODE=00, A=2 -> D=8'h04.
5. Boundaries: DWELL=1, sweep from A=7 -> D=8'h80 one clk, then DONE. Scan with START on a dwell boundary -> stop without advancing. MODE change mid-scan -> no effect.
6. DEC_ACTIVE_LOW_EN defined: repeat scenarios 1 and 3 -> D is the inverse (reset 8'hFF, A=2 -> 8'hFB); IDX/BUSY/DONE are identical to the active-high runs.

Source files
------------

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared encodings for the scanning one-hot decoder family.
//   mode_e  : MODE input encodings (direct / continuous scan / one-shot sweep /
//             hold)
//   state_e : control FSM state encodings (also exported for debug)
//   dwell_cnt_w() : width of a dwell counter that must hold values 0..DWELL
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_SWEEP = 2'b10
  } state_e;

  // The counter is sized to hold DWELL itself, so the compare against
  // DWELL-1 never needs a wider intermediate.
  function automatic int dwell_cnt_w(input int dwell);
    return $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// -----------------------------------------------------------------------------
// decoder_scan_n_if
// Bundles the control inputs and select outputs of decoder_scan_n.
//   E, MODE, A, START : driven by the master (controller / testbench)
//   D, IDX, BUSY, DONE: driven by the slave (decoder_scan_n)
//   dbg_state         : current FSM state, for observation only
// Handshake semantics: there is no valid/ready pair. START is a single-cycle
// request sampled on the rising clock edge; it is only acted on in IDLE
// (to begin a run) and in SCAN (to stop). DONE is a one-cycle completion
// pulse with no back-pressure; a consumer must sample it on the cycle it is
// high.
// -----------------------------------------------------------------------------
interface decoder_scan_n_if #(
  parameter int SEL_W = 3
);
  import decoder_pkg::*;

  localparam int OUT_W = 2 ** SEL_W;

  logic             E;
  logic [1:0]       MODE;
  logic [SEL_W-1:0] A;
  logic             START;
  logic [OUT_W-1:0] D;
  logic [SEL_W-1:0] IDX;
  logic             BUSY;
  logic             DONE;
  state_e           dbg_state;

  modport master (
    output E, MODE, A, START,
    input  D, IDX, BUSY, DONE, dbg_state
  );

  modport slave (
    input  E, MODE, A, START,
    output D, IDX, BUSY, DONE, dbg_state
  );

endinterface

// File: rtl/decoder_scan_n_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts cycles 0..DWELL-1 while enabled and flags the last one.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count this cycle
//   tick     : high on the enabled cycle where the count equals DWELL-1;
//              the counter wraps to 0 on that edge
// DWELL must be >= 1; with DWELL=1 tick is high on every enabled cycle.
// -----------------------------------------------------------------------------
module dwell_counter
  import decoder_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = dwell_cnt_w(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// -----------------------------------------------------------------------------
// decoder_scan_n
// Registered N-to-2^N one-hot decoder with enable and automatic line scanning.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : decoder_scan_n_if.slave
//     E     enable; low forces D inactive and aborts any run
//     MODE  00 direct, 01 continuous scan, 10 one-shot sweep, 11 hold
//     A     direct address / start index of a scan or sweep
//     START single-cycle request: begins scan/sweep, stops a continuous scan
//     D     registered one-hot select (one-cold when DEC_ACTIVE_LOW_EN)
//     IDX   index currently selected (meaningful while D is active)
//     BUSY  high in SCAN or SWEEP
//     DONE  one-cycle pulse when a sweep finishes
//     dbg_state current FSM state
// Parameters: SEL_W (select width), DWELL (cycles per line when scanning, >=1).
// Build option: define DEC_ACTIVE_LOW_EN to drive D as the bitwise inverse of
// the internal one-hot (74x138 style). IDX/BUSY/DONE are unaffected.
// -----------------------------------------------------------------------------
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  decoder_scan_n_if.slave bus
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

  state_e           state_q, state_n;
  logic [OUT_W-1:0] d_q, d_n;        // internal active-high one-hot
  logic [SEL_W-1:0] idx_q, idx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             cnt_clr, cnt_en, tick;
  logic [SEL_W-1:0] idx_inc;
  mode_e            mode;

  assign mode    = mode_e'(bus.MODE);
  assign idx_inc = idx_q + SEL_W'(1);   // natural wrap gives the SCAN rollover

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      d_q     <= d_n;
      idx_q   <= idx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    d_n     = d_q;
    idx_n   = idx_q;
    done_n  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!bus.E) begin
          d_n = '0;
        end else begin
          unique case (mode)
            MODE_DIRECT: begin
              d_n   = OUT_W'(1) << bus.A;
              idx_n = bus.A;
            end
            MODE_SCAN, MODE_SWEEP: begin
              // Without START, scan/sweep modes simply keep the last select.
              if (bus.START) begin
                state_n = (mode == MODE_SCAN) ? ST_SCAN : ST_SWEEP;
                d_n     = OUT_W'(1) << bus.A;
                idx_n   = bus.A;
              end
            end
            MODE_HOLD: begin
              // D and IDX keep their last values.
            end
            default: begin
            end
          endcase
        end
      end

      ST_SCAN: begin
        if (!bus.E || bus.START) begin
          // Stop takes precedence over a coincident dwell boundary.
          state_n = ST_IDLE;
          d_n     = '0;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (tick) begin
            idx_n = idx_inc;
            d_n   = OUT_W'(1) << idx_inc;
          end
        end
      end

      ST_SWEEP: begin
        if (!bus.E) begin
          state_n = ST_IDLE;
          d_n     = '0;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (tick) begin
            if (idx_q == LAST_IDX) begin
              state_n = ST_IDLE;
              d_n     = '0;
              done_n  = 1'b1;
            end else begin
              idx_n = idx_inc;
              d_n   = OUT_W'(1) << idx_inc;
            end
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        d_n     = '0;
        cnt_clr = 1'b1;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

`ifdef DEC_ACTIVE_LOW_EN
  assign bus.D = ~d_q;
`else
  assign bus.D = d_q;
`endif

  assign bus.IDX       = idx_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.dbg_state = state_q;

endmodule
